// File: rtl/cla_pkg.sv
// Shared types and sizing for the cache-line to burst adaptor.
// Optional feature macro: CLA_POSTED_WRITE_EN.
package cla_pkg;

  localparam int LINE_W      = 256;
  localparam int BURST_W     = 64;
  localparam int BEATS       = LINE_W / BURST_W;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_W       = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_DONE,
    WR,
    WR_DONE
  } cla_state_t;

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] beat_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  localparam cnt_t LAST_BEAT = cnt_t'(BEATS - 1);

endpackage

// File: rtl/cla_line_buffer.sv
// Line register: beat-indexed fill for reads, full-line load for writes,
// and a beat-indexed read mux feeding the burst write data.
module cla_line_buffer
  import cla_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [LINE_W-1:0]  line_d_i,
  input  logic               beat_we,
  input  logic [CNT_W-1:0]   beat_idx,
  input  logic [BURST_W-1:0] beat_d_i,
  output logic [LINE_W-1:0]  line_q_o,
  output logic [BURST_W-1:0] beat_q_o
);

  line_t buf_q, buf_d;

  always_comb begin
    buf_d = buf_q;
    if (load_en) begin
      buf_d = line_d_i;
    end else if (beat_we) begin
      buf_d[BURST_W*beat_idx +: BURST_W] = beat_d_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign line_q_o = buf_q;
  assign beat_q_o = buf_q[BURST_W*beat_idx +: BURST_W];

endmodule

// File: rtl/cacheline_adaptor.sv
// Turns one cache-line read/write into a 4-beat memory burst.
// CLA_POSTED_WRITE_EN: acknowledge writes on the first WR cycle.
module cacheline_adaptor
  import cla_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  cla_state_t  state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        load_en;
  logic        beat_we;
  beat_t       beat_q;

  logic unused_offset;
  assign unused_offset = ^address_i[OFFSET_BITS-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    load_en = 1'b0;
    beat_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (write_i || read_i) begin
          addr_d = {address_i[31:OFFSET_BITS],
                    {OFFSET_BITS{1'b0}}};
          cnt_d  = '0;
        end
        // Write wins when both strobes are up.
        if (write_i) begin
          state_d = WR;
          load_en = 1'b1;
        end else if (read_i) begin
          state_d = RD;
        end
      end
      RD: begin
        if (resp_i) begin
          beat_we = 1'b1;
          cnt_d   = cnt_q + cnt_t'(1);
          if (cnt_q == LAST_BEAT) state_d = RD_DONE;
        end
      end
      WR: begin
        if (resp_i) begin
          cnt_d = cnt_q + cnt_t'(1);
          if (cnt_q == LAST_BEAT) state_d = WR_DONE;
        end
      end
      RD_DONE: state_d = IDLE;
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  cla_line_buffer u_buf (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .line_d_i (line_i),
    .beat_we  (beat_we),
    .beat_idx (cnt_q),
    .beat_d_i (burst_i),
    .line_q_o (line_o),
    .beat_q_o (beat_q)
  );

  assign read_o    = (state_q == RD);
  assign write_o   = (state_q == WR);
  assign address_o = addr_q;
  assign burst_o   = write_o ? beat_q : '0;

`ifdef CLA_POSTED_WRITE_EN
  logic post_q, post_d;

  assign post_d = (state_q == IDLE) && write_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      post_q <= 1'b0;
    end else begin
      post_q <= post_d;
    end
  end

  assign resp_o = (state_q == RD_DONE) || post_q;
`else
  assign resp_o = (state_q == RD_DONE) || (state_q == WR_DONE);
`endif

endmodule
